// File: rtl/vga_pkg.sv
// Shared VGA definitions: RRRGGGBB palette, tile-grid geometry and tile-entry layout.
// Used by the pixel fetch pipeline and the CPU-side tile writer.
package vga_pkg;

    localparam logic [7:0] BLACK   = 8'b000_000_00;
    localparam logic [7:0] BLUE    = 8'b000_000_11;
    localparam logic [7:0] GREEN   = 8'b000_111_00;
    localparam logic [7:0] CYAN    = 8'b000_111_11;
    localparam logic [7:0] RED     = 8'b111_000_00;
    localparam logic [7:0] MAGENTA = 8'b111_000_11;
    localparam logic [7:0] YELLOW  = 8'b111_111_00;
    localparam logic [7:0] WHITE   = 8'b111_111_11;

    localparam int COLS    = 40;
    localparam int ROWS    = 30;
    localparam int GLYPH_W = 16;
    localparam int GLYPH_H = 16;

    localparam int TILE_PAL_MSB   = 7;
    localparam int TILE_PAL_LSB   = 5;
    localparam int TILE_GLYPH_MSB = 4;
    localparam int TILE_GLYPH_LSB = 0;

    typedef struct packed {
        logic [TILE_PAL_MSB-TILE_PAL_LSB:0]     pal;
        logic [TILE_GLYPH_MSB-TILE_GLYPH_LSB:0] glyph;
    } tile_entry_t;

    function automatic logic [7:0] palette(input logic [2:0] idx);
        logic [7:0] color;
        case (idx)
            3'd0:    color = BLACK;
            3'd1:    color = BLUE;
            3'd2:    color = GREEN;
            3'd3:    color = CYAN;
            3'd4:    color = RED;
            3'd5:    color = MAGENTA;
            3'd6:    color = YELLOW;
            3'd7:    color = WHITE;
            default: color = BLACK;
        endcase
        return color;
    endfunction

endpackage

// File: rtl/tile_addr_calc.sv
// Combinational active-window test and raw-count to tile-grid mapping.
// The x/y offsets are forced to zero outside the window so no wrapped value leaks out.
module tile_addr_calc
#(
    parameter int HSTART = 145,
    parameter int VSTART = 32,
    parameter int COLS   = 40,
    parameter int ROWS   = 30
) (
    input  logic [9:0]  h_count,
    input  logic [9:0]  v_count,
    output logic        in_window,
    output logic        v_active,
    output logic [3:0]  x_in,
    output logic [3:0]  y_in,
    output logic [10:0] tile_addr
);
    import vga_pkg::GLYPH_W;
    import vga_pkg::GLYPH_H;

    localparam logic [9:0] H_LO = 10'(HSTART);
    localparam logic [9:0] H_HI = 10'(HSTART + COLS * GLYPH_W);
    localparam logic [9:0] V_LO = 10'(VSTART);
    localparam logic [9:0] V_HI = 10'(VSTART + ROWS * GLYPH_H);

    logic       h_active_s;
    logic [9:0] x_s;
    logic [8:0] y_s;
    logic [5:0] col_s;
    logic [4:0] row_s;

    // Window test, grid coordinates and row*40+col done as two shifts plus an add.
    always_comb begin
        h_active_s = (h_count >= H_LO) && (h_count < H_HI);
        v_active   = (v_count >= V_LO) && (v_count < V_HI);
        in_window  = h_active_s && v_active;
        if (h_active_s) begin
            x_s = h_count - H_LO;
        end else begin
            x_s = 10'd0;
        end
        if (v_active) begin
            y_s = 9'(v_count - V_LO);
        end else begin
            y_s = 9'd0;
        end
        col_s     = x_s[9:4];
        row_s     = y_s[8:4];
        x_in      = x_s[3:0];
        y_in      = y_s[3:0];
        tile_addr = ({6'd0, row_s} << 5) + ({6'd0, row_s} << 3) + {5'd0, col_s};
    end

endmodule

// File: rtl/glyph_fetch.sv
// Three-stage tile/glyph fetch pipeline producing one RRRGGGBB pixel per pixEn tick,
// with the timing strobes delayed by the same three ticks.
module glyph_fetch #(
    parameter int         HSTART   = 145,
    parameter int         VSTART   = 32,
    parameter int         COLS     = 40,
    parameter int         ROWS     = 30,
    parameter logic [7:0] BG_COLOR = 8'h00
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        pixEn,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    input  logic        brightIn,
    input  logic        hSyncIn,
    input  logic        vSyncIn,
    output logic [10:0] tileAddr,
    input  logic [7:0]  tileData,
    output logic [8:0]  glyphAddr,
    input  logic [15:0] glyphData,
    output logic [7:0]  pixelData,
    output logic        brightOut,
    output logic        hSyncOut,
    output logic        vSyncOut,
    output logic        vBlank
);
    import vga_pkg::tile_entry_t;
    import vga_pkg::palette;

    logic        in_window_s;
    logic        v_active_s;
    logic [3:0]  x_in_s;
    logic [3:0]  y_in_s;
    logic [10:0] tile_addr_s;

    logic [10:0] tile_addr_r;
    logic        v0_r;
    logic [3:0]  x_in0_r;
    logic [3:0]  y_in0_r;
    logic        bright0_r, hsync0_r, vsync0_r;
    logic        vblank_r;

    logic [8:0]  glyph_addr_r;
    logic        v1_r;
    logic [2:0]  pal1_r;
    logic [3:0]  x_in1_r;
    logic        bright1_r, hsync1_r, vsync1_r;

    logic [7:0]  pixel_r;
    logic        bright2_r, hsync2_r, vsync2_r;

    tile_entry_t tile_s;
    logic        lit_s;
    logic [7:0]  pix_next_s;

    tile_addr_calc #(
        .HSTART (HSTART),
        .VSTART (VSTART),
        .COLS   (COLS),
        .ROWS   (ROWS)
    ) u_tile_addr_calc (
        .h_count   (hCount),
        .v_count   (vCount),
        .in_window (in_window_s),
        .v_active  (v_active_s),
        .x_in      (x_in_s),
        .y_in      (y_in_s),
        .tile_addr (tile_addr_s)
    );

    // S0: issue tile-map address and capture the sample's position and timing.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            tile_addr_r <= 11'd0;
            v0_r        <= 1'b0;
            x_in0_r     <= 4'd0;
            y_in0_r     <= 4'd0;
            bright0_r   <= 1'b0;
            hsync0_r    <= 1'b1;
            vsync0_r    <= 1'b1;
            vblank_r    <= 1'b1;
        end else if (pixEn) begin
            if (in_window_s) begin
                tile_addr_r <= tile_addr_s;
            end
            v0_r      <= in_window_s && brightIn;
            x_in0_r   <= x_in_s;
            y_in0_r   <= y_in_s;
            bright0_r <= brightIn;
            hsync0_r  <= hSyncIn;
            vsync0_r  <= vSyncIn;
            vblank_r  <= !v_active_s;
        end
    end

    // Tile entry decode and S2 pixel selection; glyph 0 never lights a pixel.
    always_comb begin
        tile_s = tile_entry_t'(tileData);
        lit_s  = glyphData[4'd15 - x_in1_r];
        if (v1_r && lit_s) begin
            pix_next_s = palette(pal1_r);
        end else begin
            pix_next_s = BG_COLOR;
        end
    end

    // S1: issue glyph-row address and capture palette/validity from the tile entry.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            glyph_addr_r <= 9'd0;
            v1_r         <= 1'b0;
            pal1_r       <= 3'd0;
            x_in1_r      <= 4'd0;
            bright1_r    <= 1'b0;
            hsync1_r     <= 1'b1;
            vsync1_r     <= 1'b1;
        end else if (pixEn) begin
            glyph_addr_r <= {tile_s.glyph, y_in0_r};
            v1_r         <= v0_r && (tile_s.glyph != 5'd0);
            pal1_r       <= tile_s.pal;
            x_in1_r      <= x_in0_r;
            bright1_r    <= bright0_r;
            hsync1_r     <= hsync0_r;
            vsync1_r     <= vsync0_r;
        end
    end

    // S2: register the pixel and the aligned timing strobes.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            pixel_r   <= BG_COLOR;
            bright2_r <= 1'b0;
            hsync2_r  <= 1'b1;
            vsync2_r  <= 1'b1;
        end else if (pixEn) begin
            pixel_r   <= pix_next_s;
            bright2_r <= bright1_r;
            hsync2_r  <= hsync1_r;
            vsync2_r  <= vsync1_r;
        end
    end

    assign tileAddr  = tile_addr_r;
    assign glyphAddr = glyph_addr_r;
    assign pixelData = pixel_r;
    assign brightOut = bright2_r;
    assign hSyncOut  = hsync2_r;
    assign vSyncOut  = vsync2_r;
    assign vBlank    = vblank_r;

endmodule

// File: doc/glyph_fetch.md
Name: glyph_fetch

Overview:
- Pixel-pipeline stage between VGAControl (timing) and the colour output stage.
- Converts raw hCount/vCount into a 40x30 tile grid of 16x16-pixel glyphs.
- Fetches the tile entry from tile-map memory, then the glyph row bitmap from glyph ROM, and emits one 8-bit RRRGGGBB pixel per pixel-enable.
- Delays bright/hSync/vSync by the same latency so they stay aligned with the pixel.

Parameters:
- HSTART, 145: hCount of the leftmost active pixel.
- VSTART, 32: vCount of the top active line.
- COLS, 40: tiles per row.
- ROWS, 30: tile rows.
- BG_COLOR, 8'h00: colour for background pixels and for pixels outside the active window.

Ports:
- clk  in  1: system clock.
- clear  in  1: asynchronous, active-low reset.
- pixEn  in  1: pixel-rate clock enable (one clk cycle wide); every register below advances only when pixEn=1.
- hCount  in  10: raw horizontal count from timing.
- vCount  in  10: raw vertical count from timing.
- brightIn  in  1: active-video flag from timing.
- hSyncIn  in  1: horizontal sync from timing, active low.
- vSyncIn  in  1: vertical sync from timing, active low.
- tileAddr  out  11: tile-map read address (0..1199).
- tileData  in  8: tile entry; [7:5] palette index, [4:0] glyph index. Valid 1 clk after tileAddr changes.
- glyphAddr  out  9: glyph ROM address {glyphIdx[4:0], glyphRow[3:0]}.
- glyphData  in  16: glyph row bitmap; bit 15 is the leftmost pixel. Valid 1 clk after glyphAddr changes.
- pixelData  out  8: pixel colour.
- brightOut  out  1: brightIn delayed 3 pixEn ticks.
- hSyncOut  out  1: hSyncIn delayed 3 pixEn ticks.
- vSyncOut  out  1: vSyncIn delayed 3 pixEn ticks.
- vBlank  out  1: high while the vCount stage-0 sample is outside [VSTART, VSTART+479]; tile-map writers update only while high.

Behaviour:
- Reset (clear=0), asynchronous, all outputs and state:
  - tileAddr=0, glyphAddr=0, pixelData=BG_COLOR, brightOut=0, hSyncOut=1, vSyncOut=1, vBlank=1.
  - All stage valid flags =0.
- Release is synchronous to clk. Reset mid-frame gives at least 3 pixEn ticks of black before valid pixels appear. No partial-frame state survives reset.
- Active window: HSTART <= hCount < HSTART+640 and VSTART <= vCount < VSTART+480.
  - x = hCount-HSTART, y = vCount-VSTART, both 10-bit unsigned. Compute only when inside the window; no negative wrap is ever used.
  - col = x[9:4], row = y[8:4], xIn = x[3:0], yIn = y[3:0].
- Pipeline, each stage registered on clk when pixEn=1:
  - S0: tileAddr <= row*40+col, implemented as (row<<5)+(row<<3)+col in 11 bits. Capture v0 = inWindow, xIn, yIn, and the three timing inputs. Outside the window tileAddr holds its last value and v0=0.
  - S1: glyphAddr <= {tileData[4:0], yIn}. Capture palette index tileData[7:5], v1 = v0 && (tileData[4:0] != 0). Glyph 0 is reserved blank. Pass xIn and timing through.
  - S2: pixelData <= (v1 && glyphData[15-xIn]) ? PALETTE[pal] : BG_COLOR. Drive brightOut/hSyncOut/vSyncOut from the S1 copies.
- Latency: exactly 3 pixEn ticks from hCount/vCount sample to pixelData. Timing outputs carry identical latency.
- pixEn=0: every register holds. Memory data must remain stable while its address is held.
- pixEn continuously 1 is legal; the 1-clk memory latency still lands before the next capture.
- Boundaries:
  - col 39/xIn 15 is the last active pixel of a line; the next sample is outside the window and outputs BG_COLOR.
  - Row 29/yIn 15 is the last active line; vBlank rises on the next line.
  - Tile address maximum is 1199; no address above 1199 is ever issued.
- brightIn=0 inside the numeric window still forces BG_COLOR at S2. v0 is ANDed with brightIn.

Decomposition:
- Shared package vga_pkg holds:
  - palette constants BLACK, BLUE, GREEN, CYAN, RED, MAGENTA, YELLOW, WHITE (index 0..7, RRRGGGBB);
  - PALETTE lookup function;
  - grid constants COLS, ROWS, GLYPH_W=16;
  - tile-entry field positions.
- One natural sub-module: tile_addr_calc (combinational window test, col/row/xIn/yIn, tileAddr math), reused by the future CPU-side tile writer.

Test Plan:
- Reset: assert clear=0 mid-line at hCount=300 -> pixelData=8'h00, hSyncOut=1, vSyncOut=1, brightOut=0, vBlank=1 immediately. Release -> first valid pixel after 3 pixEn ticks.
- First pixel: tile[0]=8'b010_00011, ROM[{3,0}]=16'h8001, hCount=145, vCount=32 -> 3 ticks later pixelData=8'b000_111_00.
  - hCount=146 gives 8'h00.
  - hCount=160 (xIn 15) gives green.
- Addressing: vCount=48, hCount=161 -> tileAddr=41. vCount=511, hCount=784 -> tileAddr=1199. hCount=785 -> tileAddr unchanged, pixelData=BG.
- Blank glyph: tile[5]=8'b111_00000 with ROM all 1s -> the entire tile renders 8'h00.
- Enable gating: pixEn pattern 1,0,1,0 versus constant 1 -> identical pixel sequence, and outputs unchanged on pixEn=0 cycles.
- Sync alignment: drive hSyncIn low for hCount 0..95 -> hSyncOut low exactly 3 ticks later for 96 ticks. vBlank high for vCount<32 and vCount>=512.
